drive_arbiter: RTL and testbench

//  Shares the front-wheel servo and drive motor between three command sources.

---
 rtl/drive_arbiter.sv | 163 ++++++++++++++++
 tb/tb_drive_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/drive_arbiter.sv
// Priority arbiter sharing the steering servo and drive motor between three command sources.
// Inserts a brake dwell before motor reversals/release and a steering-settle dwell before driving.
module drive_arbiter #(
   parameter int BRAKE_CYC  = 8,
   parameter int SETTLE_CYC = 5,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [8:0] fw_in,
   input  logic [5:0] motor_in,
   output logic [2:0] front_wheel,
   output logic [1:0] motor,
   output logic [2:0] grant,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DRIVE, S_BRAKE} state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] BRAKE_LAST  = CNT_W'(BRAKE_CYC - 1);
   localparam logic [CNT_W-1:0] BRAKE_SAT   = CNT_W'(BRAKE_CYC);
   localparam logic [1:0]       DIR_NONE    = 2'b00;
   localparam logic [1:0]       DIR_FWD     = 2'b01;
   localparam logic [1:0]       DIR_BACK    = 2'b10;

   state_t           r_state, w_nxt_state;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic [CNT_W-1:0] r_stop_cnt;
   logic [1:0]       r_last_dir;
   logic [2:0]       w_tgt;
   logic [2:0]       w_tgt_fw;
   logic [1:0]       w_tgt_mo;
   logic [1:0]       w_tgt_dir;
   logic             w_reversal;
   logic [2:0]       w_fw;
   logic [1:0]       w_mo;
   logic [2:0]       w_grant;
   logic             w_busy;

   function automatic logic [1:0] dir_of(input logic [1:0] m);
      if (m == 2'b00)      return DIR_NONE;
      else if (m == 2'b10) return DIR_BACK;
      else                 return DIR_FWD;
   endfunction

   // Lowest requesting index wins; re-evaluated every cycle.
   always_comb begin
      w_tgt    = 3'b000;
      w_tgt_fw = fw_in[2:0];
      w_tgt_mo = motor_in[1:0];
      if (req[0]) begin
         w_tgt = 3'b001;
      end else if (req[1]) begin
         w_tgt    = 3'b010;
         w_tgt_fw = fw_in[5:3];
         w_tgt_mo = motor_in[3:2];
      end else if (req[2]) begin
         w_tgt    = 3'b100;
         w_tgt_fw = fw_in[8:6];
         w_tgt_mo = motor_in[5:4];
      end
   end

   assign w_tgt_dir  = dir_of(w_tgt_mo);
   assign w_reversal = (w_tgt_dir != DIR_NONE) && (r_last_dir != DIR_NONE) &&
                       (w_tgt_dir != r_last_dir) && (r_stop_cnt < BRAKE_SAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_stop_cnt  <= BRAKE_SAT;
         r_last_dir  <= DIR_NONE;
         front_wheel <= 3'b000;
         motor       <= 2'b00;
         grant       <= 3'b000;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_cnt       <= w_nxt_cnt;
         front_wheel <= w_fw;
         motor       <= w_mo;
         grant       <= w_grant;
         busy        <= w_busy;
         // Track the motor value being registered so the reversal check sees the live output.
         if (w_mo != 2'b00) begin
            r_stop_cnt <= '0;
            r_last_dir <= dir_of(w_mo);
         end else if (r_stop_cnt < BRAKE_SAT) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (req != 3'b000) begin
               w_nxt_state = S_SETTLE;
               w_nxt_cnt   = '0;
            end
         end
         S_SETTLE: begin
            if (req == 3'b000) begin
               w_nxt_state = S_IDLE;
               w_nxt_cnt   = '0;
            end else if (w_tgt != grant) begin
               w_nxt_cnt = '0;
            end else if (r_cnt == SETTLE_LAST) begin
               w_nxt_state = S_DRIVE;
               w_nxt_cnt   = '0;
            end else begin
               w_nxt_cnt = r_cnt + 1'b1;
            end
         end
         S_DRIVE: begin
            if (req == 3'b000 || w_reversal) begin
               w_nxt_state = S_BRAKE;
               w_nxt_cnt   = '0;
            end
         end
         default: begin
            if (r_cnt == BRAKE_LAST) begin
               w_nxt_state = (req != 3'b000) ? S_SETTLE : S_IDLE;
               w_nxt_cnt   = '0;
            end else begin
               w_nxt_cnt = r_cnt + 1'b1;
            end
         end
      endcase
   end

   // Outputs are derived from the state being entered, then registered.
   always_comb begin
      w_fw    = 3'b000;
      w_mo    = 2'b00;
      w_grant = 3'b000;
      w_busy  = 1'b0;
      case (w_nxt_state)
         S_SETTLE: begin
            w_fw    = w_tgt_fw;
            w_grant = w_tgt;
            w_busy  = 1'b1;
         end
         S_DRIVE: begin
            w_fw    = w_tgt_fw;
            w_mo    = w_tgt_mo;
            w_grant = w_tgt;
         end
         S_BRAKE: begin
            w_fw    = front_wheel;
            w_grant = w_tgt;
            w_busy  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_drive_arbiter.sv
// Scoreboard bench for drive_arbiter: expected output vectors are queued per driven cycle and checked after the edge.
module tb_drive_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [8:0] fw_in;
   logic [5:0] motor_in;
   logic [2:0] front_wheel;
   logic [1:0] motor;
   logic [2:0] grant;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;
   logic [8:0] sb_q[$];

   drive_arbiter #(.BRAKE_CYC(8), .SETTLE_CYC(5), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .fw_in      (fw_in),
      .motor_in   (motor_in),
      .front_wheel(front_wheel),
      .motor      (motor),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got fw/mo/gnt/busy=%b_%b_%b_%b want %b_%b_%b_%b", tag,
                  got[8:6], got[5:4], got[3:1], got[0], exp[8:6], exp[5:4], exp[3:1], exp[0]);
      end
   endtask

   // Queue n expected output vectors, one per clock, and compare each after its edge.
   task automatic run(input string tag, input int n, input logic [2:0] fw, input logic [1:0] mo,
                      input logic [2:0] g, input logic b);
      logic [8:0] exp;
      for (int i = 0; i < n; i++) begin
         sb_q.push_back({fw, mo, g, b});
         @(posedge clk);
         #1;
         exp = sb_q.pop_front();
         check_val(tag, {front_wheel, motor, grant, busy}, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req = 3'b000; fw_in = '0; motor_in = '0;
      run("reset", 2, 3'b000, 2'b00, 3'b000, 1'b0);

      // Source 2 from rest: settle dwell then drive.
      rst = 1'b0; req = 3'b100; fw_in[8:6] = 3'b101; motor_in[5:4] = 2'b01;
      run("t1_settle", 5, 3'b101, 2'b00, 3'b100, 1'b1);
      run("t1_drive", 3, 3'b101, 2'b01, 3'b100, 1'b0);

      // Manual source preempts without reversal.
      req = 3'b101; fw_in[2:0] = 3'b011; motor_in[1:0] = 2'b11;
      run("t3_preempt", 2, 3'b011, 2'b11, 3'b001, 1'b0);
      req = 3'b100;
      run("t3_return", 2, 3'b101, 2'b01, 3'b100, 1'b0);

      // Reversal: brake with steering held, settle with live steering, then reverse.
      motor_in[5:4] = 2'b10;
      run("t2_brake0", 1, 3'b101, 2'b00, 3'b100, 1'b1);
      fw_in[8:6] = 3'b111;
      run("t2_brake", 7, 3'b101, 2'b00, 3'b100, 1'b1);
      run("t2_settle", 5, 3'b111, 2'b00, 3'b100, 1'b1);
      run("t2_drive", 2, 3'b111, 2'b10, 3'b100, 1'b0);

      // Stop held for a full brake time: direction change passes straight through.
      motor_in[5:4] = 2'b00;
      run("t4_stop8", 8, 3'b111, 2'b00, 3'b100, 1'b0);
      motor_in[5:4] = 2'b01;
      run("t4_pass", 2, 3'b111, 2'b01, 3'b100, 1'b0);

      // Stop one cycle short of a brake time: reversal still brakes.
      motor_in[5:4] = 2'b00;
      run("t4_stop7", 7, 3'b111, 2'b00, 3'b100, 1'b0);
      motor_in[5:4] = 2'b10;
      run("t4_brake", 8, 3'b111, 2'b00, 3'b100, 1'b1);
      run("t4_settle", 5, 3'b111, 2'b00, 3'b100, 1'b1);
      run("t4_drive", 1, 3'b111, 2'b10, 3'b100, 1'b0);

      // Full release: brake with no owner, then idle.
      req = 3'b000;
      run("t5_brake", 8, 3'b111, 2'b00, 3'b000, 1'b1);
      run("t5_idle", 2, 3'b000, 2'b00, 3'b000, 1'b0);

      // Reset mid-brake with a request held.
      req = 3'b100;
      run("t6_settle", 5, 3'b111, 2'b00, 3'b100, 1'b1);
      run("t6_drive", 1, 3'b111, 2'b10, 3'b100, 1'b0);
      motor_in[5:4] = 2'b01;
      run("t6_brake", 3, 3'b111, 2'b00, 3'b100, 1'b1);
      rst = 1'b1;
      run("t6_rst", 1, 3'b000, 2'b00, 3'b000, 1'b0);
      rst = 1'b0;
      run("t6_resettle", 2, 3'b111, 2'b00, 3'b100, 1'b1);

      // Owner change during settle restarts the dwell.
      req = 3'b110; fw_in[5:3] = 3'b001; motor_in[3:2] = 2'b01;
      run("t7_settle", 5, 3'b001, 2'b00, 3'b010, 1'b1);
      run("t7_drive", 2, 3'b001, 2'b01, 3'b010, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
